// File: rtl/hdr_pack.sv
// hdr_pack: packs eight consecutive 16-bit HDR pixels into one 128-bit word
// for the frame store, counts words per frame and resynchronises on pix_sof.
// Optional macro HDR_PACK_ERR_EN enables the short_frame pulse and the
// saturating drop_cnt; without it both outputs are tied to zero.
module hdr_pack #(
  parameter int PIX_W           = 16,
  parameter int WORDS_PER_FRAME = 38400
) (
  input  logic                 clk_25M,
  input  logic                 rst,
  input  logic [PIX_W-1:0]     pix_data,
  input  logic                 pix_valid,
  input  logic                 pix_sof,
  output logic [8*PIX_W-1:0]   hdr_data,
  output logic                 hdr_data_valid,
  output logic                 frame_done,
  output logic                 short_frame,
  output logic [15:0]          drop_cnt
);

  localparam int          LANES = 8;
  localparam logic [15:0] WPF   = 16'(WORDS_PER_FRAME);

  typedef enum logic {IDLE, PACK} state_t;

  state_t                 state_reg, state_next;
  logic [2:0]             lane_reg, lane_next;
  logic [15:0]            word_reg, word_next;
  logic [LANES-2:0]       lane_we;
  logic [PIX_W-1:0]       asm_reg [LANES-1];
  logic [8*PIX_W-1:0]     asm_word;
  logic [8*PIX_W-1:0]     hdr_data_reg, hdr_data_next;
  logic                   valid_reg, valid_next;
  logic                   done_reg, done_next;

  // Full word as it will look once lane 7 arrives: lanes 0..6 from the
  // assembly registers, lane 7 straight from the incoming pixel.
  generate
    for (genvar gi = 0; gi < LANES - 1; gi++) begin : g_lane
      assign asm_word[gi*PIX_W +: PIX_W] = asm_reg[gi];
    end
  endgenerate
  assign asm_word[(LANES-1)*PIX_W +: PIX_W] = pix_data;

  // Next-state, counter and output decode; a sof pixel always restarts lane 0.
  always_comb begin
    state_next    = state_reg;
    lane_next     = lane_reg;
    word_next     = word_reg;
    lane_we       = '0;
    hdr_data_next = hdr_data_reg;
    valid_next    = 1'b0;
    done_next     = 1'b0;
    if (pix_valid) begin
      if (pix_sof) begin
        lane_we[0] = 1'b1;
        lane_next  = 3'd1;
        word_next  = '0;
        state_next = PACK;
      end else if (state_reg == PACK) begin
        lane_next = lane_reg + 3'd1;
        if (lane_reg == 3'd7) begin
          hdr_data_next = asm_word;
          valid_next    = 1'b1;
          if (word_reg + 16'd1 == WPF) begin
            done_next  = 1'b1;
            word_next  = '0;
            state_next = IDLE;
          end else begin
            word_next = word_reg + 16'd1;
          end
        end else begin
          lane_we[lane_reg] = 1'b1;
        end
      end
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk_25M) begin
    if (rst) begin
      state_reg    <= IDLE;
      lane_reg     <= '0;
      word_reg     <= '0;
      hdr_data_reg <= '0;
      valid_reg    <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      lane_reg     <= lane_next;
      word_reg     <= word_next;
      hdr_data_reg <= hdr_data_next;
      valid_reg    <= valid_next;
      done_reg     <= done_next;
    end
  end

  // Assembly registers for lanes 0..6, written one lane per accepted pixel.
  always_ff @(posedge clk_25M) begin
    for (int i = 0; i < LANES - 1; i++) begin
      if (rst) begin
        asm_reg[i] <= '0;
      end else if (lane_we[i]) begin
        asm_reg[i] <= pix_data;
      end
    end
  end

  assign hdr_data       = hdr_data_reg;
  assign hdr_data_valid = valid_reg;
  assign frame_done     = done_reg;

`ifdef HDR_PACK_ERR_EN
  logic        short_reg;
  logic [15:0] drop_reg;
  logic        drop_evt;
  logic        short_evt;

  assign drop_evt  = (state_reg == IDLE) && pix_valid && !pix_sof;
  assign short_evt = (state_reg == PACK) && pix_valid && pix_sof;

  // Error reporting: abort pulse and saturating count of pre-sof pixels.
  always_ff @(posedge clk_25M) begin
    if (rst) begin
      short_reg <= 1'b0;
      drop_reg  <= '0;
    end else begin
      short_reg <= short_evt;
      if (drop_evt && drop_reg != 16'hFFFF) begin
        drop_reg <= drop_reg + 16'd1;
      end
    end
  end

  assign short_frame = short_reg;
  assign drop_cnt    = drop_reg;
`else
  assign short_frame = 1'b0;
  assign drop_cnt    = 16'h0;
`endif

endmodule

// File: tb/tb_hdr_pack.sv
// Directed testbench for hdr_pack with WORDS_PER_FRAME = 4.
module tb_hdr_pack;

  localparam int WPF = 4;
`ifdef HDR_PACK_ERR_EN
  localparam int ERR_EN = 1;
`else
  localparam int ERR_EN = 0;
`endif

  logic         clk_25M = 1'b0;
  logic         rst;
  logic [15:0]  pix_data;
  logic         pix_valid;
  logic         pix_sof;
  logic [127:0] hdr_data;
  logic         hdr_data_valid;
  logic         frame_done;
  logic         short_frame;
  logic [15:0]  drop_cnt;

  hdr_pack #(.PIX_W(16), .WORDS_PER_FRAME(WPF)) dut (
    .clk_25M        (clk_25M),
    .rst            (rst),
    .pix_data       (pix_data),
    .pix_valid      (pix_valid),
    .pix_sof        (pix_sof),
    .hdr_data       (hdr_data),
    .hdr_data_valid (hdr_data_valid),
    .frame_done     (frame_done),
    .short_frame    (short_frame),
    .drop_cnt       (drop_cnt)
  );

  always #20 clk_25M = ~clk_25M;

  int           n_checks = 0;
  int           n_fails  = 0;
  int           edge_cnt = 0;
  logic [127:0] words_q[$];
  int           vstamp_q[$];
  logic         done_q[$];
  int           l7_q[$];
  int           short_stamp_q[$];
  int           done_cnt  = 0;
  int           short_cnt = 0;
  int           sof_edge  = 0;
  logic [127:0] exp_w [4];

  // Monitor: log every word, frame_done and short_frame with its edge number.
  always @(posedge clk_25M) begin
    edge_cnt++;
    #1;
    if (hdr_data_valid) begin
      words_q.push_back(hdr_data);
      vstamp_q.push_back(edge_cnt);
      done_q.push_back(frame_done);
      $display("edge %0d: word %h frame_done=%0b", edge_cnt, hdr_data, frame_done);
    end
    if (frame_done) done_cnt++;
    if (short_frame) begin
      short_cnt++;
      short_stamp_q.push_back(edge_cnt);
      $display("edge %0d: short_frame", edge_cnt);
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_25M);
      #1;
    end
  endtask

  // One accepted pixel; returns at edge+1 so edge_cnt names the accept edge.
  task automatic pix(input logic [15:0] d, input logic sof);
    pix_data  = d;
    pix_valid = 1'b1;
    pix_sof   = sof;
    @(posedge clk_25M);
    #1;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  task automatic send_frame(input int base, input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      pix(16'(base + i), i == 0);
      if (i == 0) sof_edge = edge_cnt;
      if (i % 8 == 7) l7_q.push_back(edge_cnt);
      if (gaps) idle((i % 5) + 1);
    end
  endtask

  task automatic clear_log;
    words_q.delete();
    vstamp_q.delete();
    done_q.delete();
    l7_q.delete();
    short_stamp_q.delete();
    done_cnt  = 0;
    short_cnt = 0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) begin
      @(posedge clk_25M);
      #1;
      check("rst_hdr_data", hdr_data, 128'd0);
      check("rst_valid", hdr_data_valid, 1'b0);
      check("rst_frame_done", frame_done, 1'b0);
      check("rst_short", short_frame, 1'b0);
      check("rst_drop", drop_cnt, 16'd0);
    end
    rst = 1'b0;
  endtask

  task automatic check_frame(input string tag, input int first);
    for (int k = 0; k < 4; k++) begin
      check({tag, "_word"}, words_q[first + k], exp_w[k]);
      check({tag, "_done_flag"}, done_q[first + k], (k == 3) ? 1'b1 : 1'b0);
    end
  endtask

  initial begin
    exp_w[0] = 128'h0007_0006_0005_0004_0003_0002_0001_0000;
    exp_w[1] = 128'h000f_000e_000d_000c_000b_000a_0009_0008;
    exp_w[2] = 128'h0017_0016_0015_0014_0013_0012_0011_0010;
    exp_w[3] = 128'h001f_001e_001d_001c_001b_001a_0019_0018;
    rst = 1'b1; pix_data = '0; pix_valid = 1'b0; pix_sof = 1'b0;

    // Reset values
    do_reset(3);
    idle(1);
    check("post_rst_valid", hdr_data_valid, 1'b0);
    clear_log();

    // Pixels before any sof are dropped
    for (int i = 0; i < 5; i++) pix(16'h55 + 16'(i), 1'b0);
    idle(2);
    check("drop_words", words_q.size(), 0);
    check("drop_cnt", drop_cnt, (ERR_EN != 0) ? 16'd5 : 16'd0);
    do_reset(2);
    clear_log();

    // Full contiguous frame
    send_frame(0, 32, 1'b0);
    idle(3);
    check("full_nwords", words_q.size(), 4);
    check_frame("full", 0);
    for (int k = 0; k < 4; k++) check("full_latency", vstamp_q[k], l7_q[k]);
    for (int k = 1; k < 4; k++) check("full_spacing", vstamp_q[k] - vstamp_q[k-1], 8);
    check("full_done_cnt", done_cnt, 1);
    check("full_short_cnt", short_cnt, 0);
    check("full_hold", hdr_data, exp_w[3]);
    clear_log();

    // Same frame with valid gaps of 1..5 cycles
    send_frame(0, 32, 1'b1);
    idle(3);
    check("gap_nwords", words_q.size(), 4);
    check_frame("gap", 0);
    for (int k = 0; k < 4; k++) check("gap_latency", vstamp_q[k], l7_q[k]);
    check("gap_done_cnt", done_cnt, 1);
    clear_log();

    // Short frame: 13 pixels then a new sof and a full frame
    send_frame(100, 13, 1'b0);
    send_frame(0, 32, 1'b0);
    idle(3);
    check("short_nwords", words_q.size(), 5);
    check("short_word0", words_q[0], 128'h006b_006a_0069_0068_0067_0066_0065_0064);
    check("short_word0_done", done_q[0], 1'b0);
    check_frame("short_new", 1);
    check("short_done_cnt", done_cnt, 1);
    check("short_cnt", short_cnt, ERR_EN);
    check("short_edge", (short_stamp_q.size() > 0) ? short_stamp_q[0] : -1,
          (ERR_EN != 0) ? sof_edge : -1);
    clear_log();

    // Reset after lane 3 of word 1, then a clean frame
    for (int i = 0; i < 12; i++) pix(16'(i), i == 0);
    check("pre_rst_word", hdr_data, exp_w[0]);
    do_reset(2);
    idle(1);
    check("post_rst2_valid", hdr_data_valid, 1'b0);
    clear_log();
    send_frame(0, 32, 1'b0);
    idle(3);
    check("rstmid_nwords", words_q.size(), 4);
    check_frame("rstmid", 0);
    check("rstmid_done_cnt", done_cnt, 1);
    clear_log();

    // Back-to-back frames
    send_frame(0, 32, 1'b0);
    send_frame(0, 32, 1'b0);
    idle(3);
    check("b2b_nwords", words_q.size(), 8);
    check_frame("b2b_a", 0);
    check_frame("b2b_b", 4);
    check("b2b_done_cnt", done_cnt, 2);
    check("b2b_short_cnt", short_cnt, 0);
    check("b2b_drop", drop_cnt, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
